// File: rtl/rf_writeback_arbiter_if.sv
// Writeback-side bundle: ALU and memory result handshakes, regfile write
// port and the pending-write mask seen by issue.
interface rf_writeback_arbiter_if #(
    parameter int DATA_W = 28,
    parameter int ADDR_W = 4
);
    logic                  alu_valid;
    logic                  alu_ready;
    logic [ADDR_W-1:0]     alu_dest;
    logic [DATA_W-1:0]     alu_data;
    logic                  mem_valid;
    logic                  mem_ready;
    logic [ADDR_W-1:0]     mem_dest;
    logic [DATA_W-1:0]     mem_data;
    logic                  rf_wen;
    logic [ADDR_W-1:0]     rf_dest;
    logic [DATA_W-1:0]     rf_data;
    logic [2**ADDR_W-1:0]  busy;

    // Producer side (ALU/memory pipes, regfile, issue)
    modport master (
        output alu_valid, alu_dest, alu_data, mem_valid, mem_dest, mem_data,
        input  alu_ready, mem_ready, rf_wen, rf_dest, rf_data, busy
    );

    // Arbiter side
    modport slave (
        input  alu_valid, alu_dest, alu_data, mem_valid, mem_dest, mem_data,
        output alu_ready, mem_ready, rf_wen, rf_dest, rf_data, busy
    );
endinterface

// File: rtl/rf_writeback_arbiter.sv
// Writeback arbiter: ALU results win the single regfile write port unless the
// memory-result FIFO is full or its head has been bypassed MAX_WAIT cycles.
// Memory results are queued in order; busy[] flags registers with queued writes.
module rf_writeback_arbiter #(
    parameter int DATA_W   = 28,
    parameter int ADDR_W   = 4,
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    rf_writeback_arbiter_if.slave  wb
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int NREG   = 2**ADDR_W;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    logic [ADDR_W-1:0] fifo_dest_q [DEPTH];
    logic [ADDR_W-1:0] fifo_dest_d [DEPTH];
    logic [DATA_W-1:0] fifo_data_q [DEPTH];
    logic [DATA_W-1:0] fifo_data_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              rf_wen_q, rf_wen_d;
    logic [ADDR_W-1:0] rf_dest_q, rf_dest_d;
    logic [DATA_W-1:0] rf_data_q, rf_data_d;

    logic              force_mem, alu_ready, mem_ready, alu_take, pop, push;
    logic [NREG-1:0]   busy;

    // Source selection, FIFO bookkeeping and starvation counter
    always_comb begin
        force_mem  = (count_q == CNT_W'(DEPTH)) || (wait_cnt_q >= WAIT_W'(MAX_WAIT));
        alu_ready  = ~force_mem;
        mem_ready  = (count_q < CNT_W'(DEPTH));
        alu_take   = wb.alu_valid & alu_ready;
        pop        = ~alu_take & (count_q != '0);
        // dest 0 writes are accepted but never queued
        push       = wb.mem_valid & mem_ready & (wb.mem_dest != '0);

        fifo_dest_d = fifo_dest_q;
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        rf_wen_d    = 1'b0;
        rf_dest_d   = rf_dest_q;
        rf_data_d   = rf_data_q;

        if (push) begin
            fifo_dest_d[wr_ptr_q] = wb.mem_dest;
            fifo_data_d[wr_ptr_q] = wb.mem_data;
            wr_ptr_d              = wr_ptr_q + 1'b1;
        end

        if (alu_take) begin
            rf_wen_d  = (wb.alu_dest != '0);
            rf_dest_d = wb.alu_dest;
            rf_data_d = wb.alu_data;
        end else if (pop) begin
            rf_wen_d  = (fifo_dest_q[rd_ptr_q] != '0);
            rf_dest_d = fifo_dest_q[rd_ptr_q];
            rf_data_d = fifo_data_q[rd_ptr_q];
            rd_ptr_d  = rd_ptr_q + 1'b1;
        end

        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        // Counts cycles the current head has been passed over by the ALU
        if (pop || count_q == '0)
            wait_cnt_d = '0;
        else if (wait_cnt_q < WAIT_W'(MAX_WAIT))
            wait_cnt_d = wait_cnt_q + 1'b1;
        else
            wait_cnt_d = wait_cnt_q;
    end

    // Pending-write mask: decode dests of occupied FIFO slots
    always_comb begin
        logic [PTR_W-1:0] off;
        busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PTR_W'(i) - rd_ptr_q;
            if (CNT_W'(off) < count_q)
                busy[fifo_dest_q[i]] = 1'b1;
        end
        busy[0] = 1'b0;
    end

    // State registers; reset discards any queued results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_dest_q[i] <= '0;
                fifo_data_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wait_cnt_q <= '0;
            rf_wen_q   <= 1'b0;
            rf_dest_q  <= '0;
            rf_data_q  <= '0;
        end else begin
            fifo_dest_q <= fifo_dest_d;
            fifo_data_q <= fifo_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wait_cnt_q  <= wait_cnt_d;
            rf_wen_q    <= rf_wen_d;
            rf_dest_q   <= rf_dest_d;
            rf_data_q   <= rf_data_d;
        end
    end

    assign wb.alu_ready = alu_ready;
    assign wb.mem_ready = mem_ready;
    assign wb.rf_wen    = rf_wen_q;
    assign wb.rf_dest   = rf_dest_q;
    assign wb.rf_data   = rf_data_q;
    assign wb.busy      = busy;
endmodule
